messbauer_sweep_sequencer: RTL

Controller that sequences the velocity (Doppler) sweep of the Mössbauer test environment. On a start request it issues a start-of-sweep pulse and then steps through a power-of-two number of channels at a fixed clock period. It provides the 12-bit DAC code for the velocity drive in sawtooth or triangle mode, and channel-advance strobes for the spectrum accumulator. It repeats for a programmed number of sweeps. It sits between the host/test control logic and the velocity DAC / channel counter datapath.

---
 rtl/messbauer_sweep_sequencer_if.sv | 31 +++
 rtl/messbauer_sweep_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/messbauer_sweep_sequencer_if.sv
// Host/datapath bundle for the Mossbauer velocity sweep sequencer.
// master = host control side, slave = the sequencer itself.
interface messbauer_sweep_sequencer_if #(
  parameter int CHANNEL_BITS = 12
);
  logic                    start;
  logic                    abort;
  logic                    mode;
  logic [15:0]             cycles;
  logic                    v_start;
  logic                    v_channel;
  logic [CHANNEL_BITS-1:0] channel;
  logic                    direction;
  logic [CHANNEL_BITS-1:0] dac_value;
  logic                    dac_load;
  logic [15:0]             sweep_count;
  logic                    busy;
  logic                    done;

  modport master (
    output start, abort, mode, cycles,
    input  v_start, v_channel, channel, direction, dac_value, dac_load,
           sweep_count, busy, done
  );

  modport slave (
    input  start, abort, mode, cycles,
    output v_start, v_channel, channel, direction, dac_value, dac_load,
           sweep_count, busy, done
  );
endinterface

// File: rtl/messbauer_sweep_sequencer.sv
// Velocity (Doppler) sweep sequencer: start pulse, per-channel strobes and
// sawtooth/triangle DAC codes, repeated for a programmed number of sweeps.
module messbauer_sweep_sequencer #(
  parameter int CHANNEL_BITS   = 12,
  parameter int CHANNEL_PERIOD = 8,
  parameter int START_PULSE    = 4
) (
  input  logic                          clk,
  input  logic                          areset_n,
  messbauer_sweep_sequencer_if.slave    bus
);

  localparam int PCW = (CHANNEL_PERIOD > 1) ? $clog2(CHANNEL_PERIOD) : 1;
  localparam int SPW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(CHANNEL_PERIOD - 1);
  localparam logic [PCW-1:0] PC_PRE  = PCW'(CHANNEL_PERIOD - 2);
  localparam logic [SPW-1:0] SP_LAST = SPW'(START_PULSE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} state_t;

  state_t                  r_state;
  logic [PCW-1:0]          r_pcnt;
  logic [SPW-1:0]          r_scnt;
  logic                    r_mode;
  logic [15:0]             r_cycles;
  logic [15:0]             r_sweep_count;
  logic [CHANNEL_BITS-1:0] r_channel;
  logic [CHANNEL_BITS-1:0] r_dac_value;
  logic                    r_direction;
  logic                    r_v_start;
  logic                    r_v_channel;
  logic                    r_dac_load;
  logic                    r_busy;
  logic                    r_done;

  logic [CHANNEL_BITS-1:0] w_next_ch;
  logic                    w_last_ch;
  logic [15:0]             w_next_sc;
  logic                    w_sweep_end;
  logic [CHANNEL_BITS:0]   w_code;

  // Returns {direction, dac_code}; triangle folds the doubled index downward
  // once the channel MSB is set.
  function automatic logic [CHANNEL_BITS:0] dac_code(
    input logic                    m,
    input logic [CHANNEL_BITS-1:0] ch
  );
    logic                    dir;
    logic [CHANNEL_BITS-1:0] s;
    if (!m) begin
      return {1'b0, ch};
    end
    dir = ch[CHANNEL_BITS-1];
    s   = ch << 1;
    return {dir, (dir ? ~s : s)};
  endfunction

  always_comb begin
    w_next_ch   = r_channel + CHANNEL_BITS'(1);
    w_last_ch   = (r_channel == '1);
    w_next_sc   = r_sweep_count + 16'd1;
    w_sweep_end = (r_cycles != 16'd0) && (w_next_sc == r_cycles);
    w_code      = dac_code(r_mode, w_next_ch);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state       <= ST_IDLE;
      r_pcnt        <= '0;
      r_scnt        <= '0;
      r_mode        <= 1'b0;
      r_cycles      <= '0;
      r_sweep_count <= '0;
      r_channel     <= '0;
      r_dac_value   <= '0;
      r_direction   <= 1'b0;
      r_v_start     <= 1'b0;
      r_v_channel   <= 1'b0;
      r_dac_load    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_dac_load <= 1'b0;
      r_done     <= 1'b0;
      if (bus.abort && (r_state != ST_IDLE)) begin
        // Abort silences everything but the completed-sweep tally.
        r_state     <= ST_IDLE;
        r_pcnt      <= '0;
        r_scnt      <= '0;
        r_channel   <= '0;
        r_dac_value <= '0;
        r_direction <= 1'b0;
        r_v_start   <= 1'b0;
        r_v_channel <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_mode        <= bus.mode;
              r_cycles      <= bus.cycles;
              r_sweep_count <= '0;
              r_state       <= ST_START;
              r_scnt        <= '0;
              r_v_start     <= 1'b1;
              r_busy        <= 1'b1;
              r_dac_load    <= 1'b1;
              r_channel     <= '0;
              r_dac_value   <= '0;
              r_direction   <= 1'b0;
            end
          end
          ST_START: begin
            if (r_scnt == SP_LAST) begin
              r_state   <= ST_RUN;
              r_pcnt    <= '0;
              r_v_start <= 1'b0;
            end else begin
              r_scnt <= r_scnt + SPW'(1);
            end
          end
          ST_RUN: begin
            if (r_pcnt == PC_LAST) begin
              r_pcnt      <= '0;
              r_v_channel <= 1'b0;
              r_dac_load  <= 1'b1;
              if (!w_last_ch) begin
                r_channel   <= w_next_ch;
                r_direction <= w_code[CHANNEL_BITS];
                r_dac_value <= w_code[CHANNEL_BITS-1:0];
              end else begin
                r_sweep_count <= w_next_sc;
                r_channel     <= '0;
                r_dac_value   <= '0;
                r_direction   <= 1'b0;
                if (w_sweep_end) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end else begin
                  r_state   <= ST_START;
                  r_scnt    <= '0;
                  r_v_start <= 1'b1;
                end
              end
            end else begin
              r_pcnt      <= r_pcnt + PCW'(1);
              r_v_channel <= (r_pcnt == PC_PRE);
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.v_start     = r_v_start;
  assign bus.v_channel   = r_v_channel;
  assign bus.channel     = r_channel;
  assign bus.direction   = r_direction;
  assign bus.dac_value   = r_dac_value;
  assign bus.dac_load    = r_dac_load;
  assign bus.sweep_count = r_sweep_count;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
